// File: rtl/vc_vr_converter.sv
// vc_vr_converter
//   Bridges a valid/credit upstream interface to a valid/ready downstream
//   interface through a CREDIT_NUM-deep FIFO. The sender gets CREDIT_NUM
//   credits after reset and one further credit for every beat that leaves
//   the FIFO.
// Ports:
//   clk        : clock, rising edge
//   rst_n      : synchronous reset, active HIGH (1 = reset)
//   s_data_i   : upstream payload
//   s_valid_i  : upstream valid, one beat per asserted cycle
//   s_credit_o : one-cycle credit-return pulse
//   m_data_o   : downstream payload (oldest entry)
//   m_valid_o  : downstream valid (FIFO non-empty)
//   m_ready_i  : downstream ready
module vc_vr_converter #(
   parameter int DATA_WIDTH = 8,
   parameter int CREDIT_NUM = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] s_data_i,
   input  logic                  s_valid_i,
   output logic                  s_credit_o,
   output logic [DATA_WIDTH-1:0] m_data_o,
   output logic                  m_valid_o,
   input  logic                  m_ready_i
);

   localparam int PTR_W = (CREDIT_NUM > 1) ? $clog2(CREDIT_NUM) : 1;
   localparam int CNT_W = $clog2(CREDIT_NUM + 1);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(CREDIT_NUM - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CREDIT_NUM);

   logic [DATA_WIDTH-1:0] mem [CREDIT_NUM];
   logic [PTR_W-1:0]      wr_ptr, rd_ptr;
   logic [CNT_W-1:0]      count;
   logic [CNT_W-1:0]      num_of_credits;
   logic [CNT_W-1:0]      pending;       // credit pulses owed but not yet sent

   logic full, push, pop;
   logic [CNT_W:0] avail;                 // one extra bit: pending + this cycle's pop
   logic           credit_nxt;
   logic [CNT_W-1:0] pending_nxt;

   assign full      = (count == CNT_FULL);
   assign m_valid_o = (count != '0);
   assign pop       = m_valid_o & m_ready_i;
   // A full FIFO still accepts a beat when a slot frees in the same cycle.
   assign push      = s_valid_i & (~full | pop);
   // Gated so the output reads zero while empty/in reset; mem itself is not reset.
   assign m_data_o  = m_valid_o ? mem[rd_ptr] : '0;

   // Credit return: one pulse per cycle while anything is owed; pops that
   // arrive during the initial grant simply add to the backlog.
   always_comb begin
      avail       = {1'b0, pending} + (CNT_W+1)'(pop);
      credit_nxt  = (avail != '0);
      pending_nxt = CNT_W'(avail - (CNT_W+1)'(credit_nxt));
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= s_data_i;
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         count          <= '0;
         num_of_credits <= CNT_FULL;
         pending        <= CNT_FULL;
         s_credit_o     <= 1'b0;
      end else begin
         if (push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
         if (pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
         case ({push, pop})
            2'b10: begin
               count          <= count + 1'b1;
               num_of_credits <= num_of_credits - 1'b1;
            end
            2'b01: begin
               count          <= count - 1'b1;
               num_of_credits <= num_of_credits + 1'b1;
            end
            default: ;
         endcase
         pending    <= pending_nxt;
         s_credit_o <= credit_nxt;
      end
   end

endmodule

// File: tb/tb_vc_vr_converter.sv
// Directed self-checking bench for vc_vr_converter (DATA_WIDTH=8, CREDIT_NUM=2).
// Inputs change 1 time unit after the rising edge; outputs are checked there too.
module tb_vc_vr_converter;

   logic       tb_clk = 1'b0;
   logic       rst_n;
   logic [7:0] s_data_i;
   logic       s_valid_i;
   logic       s_credit_o;
   logic [7:0] m_data_o;
   logic       m_valid_o;
   logic       m_ready_i;

   int checks = 0;
   int errors = 0;
   int pulses;

   logic [7:0] stream [6] = '{8'h3C, 8'hE1, 8'h07, 8'h9A, 8'h52, 8'hFF};

   always #5 tb_clk = ~tb_clk;

   vc_vr_converter #(.DATA_WIDTH(8), .CREDIT_NUM(2)) dut (
      .clk        (tb_clk),
      .rst_n      (rst_n),
      .s_data_i   (s_data_i),
      .s_valid_i  (s_valid_i),
      .s_credit_o (s_credit_o),
      .m_data_o   (m_data_o),
      .m_valid_o  (m_valid_o),
      .m_ready_i  (m_ready_i)
   );

   task automatic tick();
      @(posedge tb_clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n = 1'b1; s_data_i = '0; s_valid_i = 1'b0; m_ready_i = 1'b0;

      // reset held 10 cycles
      repeat (10) tick();
      check("rst_valid",   32'(m_valid_o), 0);
      check("rst_credit",  32'(s_credit_o), 0);
      check("rst_data",    32'(m_data_o), 0);
      check("rst_credits", 32'(dut.num_of_credits), 2);

      // initial grant: exactly two pulses
      rst_n = 1'b0;
      tick(); check("grant_1", 32'(s_credit_o), 1);
      tick(); check("grant_2", 32'(s_credit_o), 1);
      tick(); check("grant_end", 32'(s_credit_o), 0);
      tick(); tick();
      check("grant_credits", 32'(dut.num_of_credits), 2);

      // single transfer, held while not ready
      s_data_i = 8'hA5; s_valid_i = 1'b1;
      tick(); s_valid_i = 1'b0;
      check("single_valid",   32'(m_valid_o), 1);
      check("single_data",    32'(m_data_o), 32'hA5);
      check("single_credits", 32'(dut.num_of_credits), 1);
      tick();
      check("hold_valid", 32'(m_valid_o), 1);
      check("hold_data",  32'(m_data_o), 32'hA5);
      check("hold_nocred", 32'(s_credit_o), 0);
      m_ready_i = 1'b1;
      tick(); m_ready_i = 1'b0;
      check("single_pop_valid", 32'(m_valid_o), 0);
      check("single_pop_cred",  32'(s_credit_o), 1);
      check("single_pop_credits", 32'(dut.num_of_credits), 2);
      tick();
      check("single_cred_once", 32'(s_credit_o), 0);

      // fill 11, 22
      s_valid_i = 1'b1; s_data_i = 8'h11;
      tick(); s_data_i = 8'h22;
      tick(); s_valid_i = 1'b0;
      check("fill_credits", 32'(dut.num_of_credits), 0);
      check("fill_head",    32'(m_data_o), 32'h11);

      // overflow beat 33 is dropped
      s_valid_i = 1'b1; s_data_i = 8'h33;
      tick(); s_valid_i = 1'b0;
      check("ovf_credits", 32'(dut.num_of_credits), 0);
      check("ovf_count",   32'(dut.count), 2);
      check("ovf_head",    32'(m_data_o), 32'h11);

      // drain: 11 then 22, two credit pulses
      m_ready_i = 1'b1;
      tick();
      check("drain_1_data", 32'(m_data_o), 32'h22);
      check("drain_1_cred", 32'(s_credit_o), 1);
      tick(); m_ready_i = 1'b0;
      check("drain_2_valid", 32'(m_valid_o), 0);
      check("drain_2_cred",  32'(s_credit_o), 1);
      check("drain_credits", 32'(dut.num_of_credits), 2);
      tick();
      check("drain_cred_end", 32'(s_credit_o), 0);

      // full FIFO accepts a push when a pop happens in the same cycle
      s_valid_i = 1'b1; s_data_i = 8'h44;
      tick(); s_data_i = 8'h55;
      tick(); s_data_i = 8'h66; m_ready_i = 1'b1;
      tick(); s_valid_i = 1'b0;
      check("fullpp_head",    32'(m_data_o), 32'h55);
      check("fullpp_count",   32'(dut.count), 2);
      check("fullpp_credits", 32'(dut.num_of_credits), 0);
      tick();
      check("fullpp_next", 32'(m_data_o), 32'h66);
      tick(); m_ready_i = 1'b0;
      check("fullpp_empty", 32'(m_valid_o), 0);
      tick(); tick();

      // streaming with ready held: each beat visible one cycle later
      pulses = 0;
      m_ready_i = 1'b1;
      for (int i = 0; i < 6; i++) begin
         s_valid_i = 1'b1; s_data_i = stream[i];
         tick();
         pulses += int'(s_credit_o);
         check($sformatf("stream_valid_%0d", i), 32'(m_valid_o), 1);
         check($sformatf("stream_data_%0d", i),  32'(m_data_o), 32'(stream[i]));
         check($sformatf("stream_occ_%0d", i),   32'(dut.count <= 1), 1);
      end
      s_valid_i = 1'b0;
      tick();
      pulses += int'(s_credit_o);
      check("stream_empty", 32'(m_valid_o), 0);
      tick();
      pulses += int'(s_credit_o);
      m_ready_i = 1'b0;
      check("stream_pulses", 32'(pulses), 6);
      check("stream_credits", 32'(dut.num_of_credits), 2);

      // mid-operation reset discards buffered data and regrants
      s_valid_i = 1'b1; s_data_i = 8'h77;
      tick(); s_data_i = 8'h88;
      tick(); s_valid_i = 1'b0;
      check("mid_pre_count", 32'(dut.count), 2);
      rst_n = 1'b1;
      tick(); rst_n = 1'b0;
      check("mid_valid",   32'(m_valid_o), 0);
      check("mid_cred",    32'(s_credit_o), 0);
      check("mid_credits", 32'(dut.num_of_credits), 2);
      tick(); check("mid_grant_1", 32'(s_credit_o), 1);
      tick(); check("mid_grant_2", 32'(s_credit_o), 1);
      tick(); check("mid_grant_end", 32'(s_credit_o), 0);

      // pop during the grant window: its pulse is queued behind the grant
      rst_n = 1'b1;
      tick(); rst_n = 1'b0; s_valid_i = 1'b1; s_data_i = 8'h99;
      tick(); s_valid_i = 1'b0; m_ready_i = 1'b1;
      check("q_grant_1", 32'(s_credit_o), 1);
      check("q_data",    32'(m_data_o), 32'h99);
      tick(); m_ready_i = 1'b0;
      check("q_grant_2", 32'(s_credit_o), 1);
      check("q_popped",  32'(m_valid_o), 0);
      tick(); check("q_queued", 32'(s_credit_o), 1);
      tick(); check("q_end",    32'(s_credit_o), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/vc_vr_converter.md
VC_VR_CONVERTER -- requirements
Module: vc_vr_converter

Interface
REQ-001 Parameters (name, default, meaning):
- DATA_WIDTH, 8, payload width in bits.
- CREDIT_NUM, 2, number of sender credits; also the buffer depth (>=1).

REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1, single clock; all logic on its rising edge.
- rst_n, in, 1, reset; synchronous, active-high (1 = reset).
- s_data_i, in, DATA_WIDTH, upstream payload.
- s_valid_i, in, 1, upstream valid; a one-cycle transfer per asserted cycle.
- s_credit_o, out, 1, one-cycle pulse returning one credit upstream.
- m_data_o, out, DATA_WIDTH, downstream payload (head of buffer).
- m_valid_o, out, 1, downstream valid.
- m_ready_i, in, 1, downstream ready.

Function
REQ-003 The block SHALL convert a valid/credit upstream interface into a valid/ready downstream interface through an internal FIFO of CREDIT_NUM entries of DATA_WIDTH bits.

REQ-004 A push SHALL occur on every cycle with s_valid_i=1 and the FIFO not full. When the FIFO is full, s_valid_i=1 is a protocol violation and the beat SHALL be discarded without changing state, unless a pop occurs in the same cycle, in which case the push SHALL be accepted.

REQ-005 A pop SHALL occur on every cycle with m_valid_o=1 and m_ready_i=1.

REQ-006 m_valid_o SHALL be 1 exactly when the FIFO is non-empty. m_data_o SHALL equal the oldest stored entry.
- Latency: a beat pushed in cycle N is visible on m_data_o/m_valid_o in cycle N+1.
- No combinational path from s_* to m_*.

REQ-007 m_data_o and m_valid_o SHALL hold stable while m_valid_o=1 and m_ready_i=0.

REQ-008 Data SHALL be delivered in arrival order with no loss or duplication. Simultaneous push and pop SHALL both take effect in the same cycle, and the occupancy SHALL then remain unchanged.

REQ-009 Read and write pointers SHALL wrap modulo CREDIT_NUM. Full and empty SHALL be distinguished by an occupancy count of width clog2(CREDIT_NUM+1).

REQ-010 The internal register num_of_credits SHALL hold the number of free FIFO slots:
- reloaded to CREDIT_NUM on reset;
- decremented on push;
- incremented on pop;
- unchanged on simultaneous push and pop.

REQ-011 Initial credit grant: in the CREDIT_NUM consecutive cycles after rst_n deasserts, s_credit_o SHALL pulse 1 per cycle, granting CREDIT_NUM credits to the sender.

REQ-012 After the initial grant, s_credit_o SHALL be a registered 1-cycle pulse in the cycle following each pop.
- Consecutive pops SHALL give consecutive pulses.
- Pop-triggered pulses requested during the initial grant window SHALL be queued and not lost.
- Total pulses SHALL equal CREDIT_NUM plus the number of pops.

Reset
REQ-013 While rst_n=1, at every clock edge:
- FIFO SHALL be emptied and pointers cleared;
- m_valid_o SHALL be 0, s_credit_o SHALL be 0, m_data_o SHALL be 0;
- num_of_credits SHALL be CREDIT_NUM;
- any pending credit pulses SHALL be cancelled.

REQ-014 Reset asserted mid-operation SHALL discard buffered data and restart the initial credit grant after deassertion.

Verification
REQ-015 Reset: hold rst_n=1 for 10 cycles -> m_valid_o=0 and s_credit_o=0. Release -> s_credit_o=1 for exactly 2 cycles; 5 cycles after release num_of_credits=2.

REQ-016 Single transfer: s_data_i=8'hA5, s_valid_i=1 for 1 cycle, m_ready_i=0 -> next cycle m_valid_o=1 and m_data_o=8'hA5, held stable. Then m_ready_i=1 for 1 cycle -> m_valid_o=0; s_credit_o pulses once in the following cycle.

REQ-017 Fill and order: push 8'h11 then 8'h22 back-to-back with m_ready_i=0 -> num_of_credits=0, m_data_o=8'h11. Pop twice -> outputs 8'h11 then 8'h22; 2 credit pulses; num_of_credits=2.

REQ-018 Overflow: FIFO full (8'h11, 8'h22), push 8'h33 with m_ready_i=0 -> beat discarded; subsequent output is 8'h11, 8'h22 only.

REQ-019 Streaming: m_ready_i=1 held, one push per cycle for 6 random beats -> every beat appears 1 cycle later in order; 6 credit pulses; occupancy never exceeds 1.

REQ-020 Mid-operation reset: with 2 entries buffered, assert rst_n=1 for 1 cycle -> m_valid_o=0. Next, the 2-cycle initial credit grant repeats.
